// File: rtl/display7seg_mux.sv
// ============================================================================
// Module   : display7seg_mux
// Purpose  : Time-multiplexed BCD driver for N_DIGITOS common-anode 7-segment
//            digits sharing one active-low segment bus.
// Option   : DISPLAY7SEG_MUX_BLANK_ZEROS_EN enables leading-zero suppression.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display7seg_mux #(
    parameter int N_DIGITOS = 4,
    parameter int DIV_SCAN  = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4*N_DIGITOS-1:0]   nota,
    input  logic                     carrega,
    input  logic                     en,
    output logic [6:0]               s_nota,
    output logic [N_DIGITOS-1:0]     anodo
);

    localparam int c_CNT_W = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
    localparam int c_IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DIV_SCAN - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_DIGITOS - 1);
    localparam logic [6:0]         c_SEG_BLANK = 7'b1111111;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [3:0]           r_buf [N_DIGITOS];

    logic                 w_last;
    logic [3:0]           w_digit;
    logic                 w_suppress;
    logic [N_DIGITOS-1:0] w_zero_lead;
    logic [N_DIGITOS-1:0] w_anodo_on;
    logic [6:0]           w_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

`ifdef DISPLAY7SEG_MUX_BLANK_ZEROS_EN
    logic w_run;

    // Walk down from the most significant digit; a digit is a leading zero
    // while every digit at or above it is zero. Digit 0 is never suppressed.
    always_comb begin
        w_zero_lead = '0;
        w_run       = 1'b1;
        for (int i = N_DIGITOS - 1; i >= 1; i--) begin
            w_run          = w_run & (r_buf[i] == 4'd0);
            w_zero_lead[i] = w_run;
        end
    end
`else
    assign w_zero_lead = '0;
`endif

    always_comb begin
        w_digit    = 4'd0;
        w_suppress = 1'b0;
        w_anodo_on = '1;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit       = r_buf[i];
                w_suppress    = w_zero_lead[i];
                w_anodo_on[i] = 1'b0;
            end
        end
    end

    assign w_last = (r_cnt == c_CNT_LAST);
    assign w_seg  = w_suppress ? c_SEG_BLANK : f_decode(w_digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            s_nota <= c_SEG_BLANK;
            anodo  <= '1;
            for (int i = 0; i < N_DIGITOS; i++) begin
                r_buf[i] <= 4'd0;
            end
        end else begin
            if (carrega) begin
                for (int i = 0; i < N_DIGITOS; i++) begin
                    r_buf[i] <= nota[4*i +: 4];
                end
            end

            if (en) begin
                s_nota <= w_seg;
                // The last count of each digit is kept dark so the anode
                // switch never overlaps the previous digit's segments.
                anodo  <= w_last ? '1 : w_anodo_on;
                if (w_last) begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                s_nota <= c_SEG_BLANK;
                anodo  <= '1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_display7seg_mux.sv
// ============================================================================
// Module   : tb_display7seg_mux
// Purpose  : Randomised and directed self-checking bench for display7seg_mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display7seg_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] nota;
    logic        carrega;
    logic        en;
    logic [6:0]  s_nota;
    logic [3:0]  anodo;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: number of enabled cycles since reset plus loaded digits.
    int          t;
    logic [3:0]  mbuf [N];
    logic [6:0]  seg_tab [16];
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    int          lit_d;

    display7seg_mux #(
        .N_DIGITOS (N),
        .DIV_SCAN  (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .nota    (nota),
        .carrega (carrega),
        .en      (en),
        .s_nota  (s_nota),
        .anodo   (anodo)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int d);
        bit lead;
        lead = 1'b1;
        for (int j = d; j < N; j++) begin
            if (mbuf[j] != 4'd0) lead = 1'b0;
        end
`ifdef DISPLAY7SEG_MUX_BLANK_ZEROS_EN
        if (d > 0 && lead) return 7'b1111111;
`endif
        return seg_tab[mbuf[d]];
    endfunction

    task automatic model_reset();
        t = 0;
        for (int i = 0; i < N; i++) mbuf[i] = 4'd0;
    endtask

    // Drive one cycle, predict the registered outputs from pre-edge state.
    task automatic step(input logic e, input logic ld, input logic [15:0] nv);
        int d;
        int ph;
        en = e; carrega = ld; nota = nv;
        @(posedge clk);
        lit_d = -1;
        if (!e) begin
            exp_seg = 7'b1111111;
            exp_an  = 4'hF;
        end else begin
            d  = (t / DIV) % N;
            ph = t % DIV;
            exp_seg = ref_seg(d);
            if (ph == DIV - 1) begin
                exp_an = 4'hF;
            end else begin
                exp_an = 4'(~(4'b0001 << d));
                lit_d  = d;
            end
            t++;
        end
        if (ld) for (int i = 0; i < N; i++) mbuf[i] = nv[4*i +: 4];
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; carrega = 1'b0; nota = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (s_nota !== 7'b1111111) begin
            n_fail++;
            $display("FAIL reset_seg: s_nota=%b expected 1111111", s_nota);
        end
        n_tests++;
        if (anodo !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_anodo: anodo=%b expected 1111", anodo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        logic [3:0] seq [16];
        seq = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,
                4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7,4'hF};
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 16'h0);
            n_tests++;
            if (anodo !== seq[k % 16] || s_nota !== exp_seg) begin
                n_fail++;
                $display("FAIL scan cyc %0d: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                         k, anodo, s_nota, seq[k % 16], exp_seg);
            end
        end
    endtask

    task automatic test_digits(input logic [15:0] w, input string nm);
        logic [6:0] want [N];
        step(1'b1, 1'b1, w);
        for (int i = 0; i < N; i++) begin
            want[i] = seg_tab[w[4*i +: 4]];
        end
        for (int k = 0; k < N * DIV + 2; k++) begin
            step(1'b1, 1'b0, w);
            n_tests++;
            if (anodo !== exp_an || s_nota !== exp_seg ||
                (lit_d >= 0 && s_nota !== want[lit_d])) begin
                n_fail++;
                $display("FAIL %s cyc %0d: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                         nm, k, anodo, s_nota, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_en_drop();
        int d;
        for (int g = 0; g < 2 * DIV && (t % DIV) != 1; g++) step(1'b1, 1'b0, nota);
        d = (t / DIV) % N;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, nota);
            n_tests++;
            if (anodo !== 4'hF || s_nota !== 7'b1111111) begin
                n_fail++;
                $display("FAIL en_drop_blank %0d: anodo=%b s_nota=%b expected 1111 1111111",
                         k, anodo, s_nota);
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, nota);
            n_tests++;
            if (anodo !== ((k < 2) ? 4'(~(4'b0001 << d)) : 4'hF) || s_nota !== exp_seg) begin
                n_fail++;
                $display("FAIL en_resume %0d: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                         k, anodo, s_nota, exp_an, exp_seg);
            end
        end
        // Drop enable during the dark cycle; the dark cycle must still follow.
        for (int g = 0; g < 2 * DIV && (t % DIV) != DIV - 1; g++) step(1'b1, 1'b0, nota);
        d = (t / DIV) % N;
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, nota);
        step(1'b1, 1'b0, nota);
        n_tests++;
        if (anodo !== 4'hF) begin
            n_fail++;
            $display("FAIL en_dark_hold: anodo=%b expected 1111", anodo);
        end
        step(1'b1, 1'b0, nota);
        n_tests++;
        if (anodo !== 4'(~(4'b0001 << ((d + 1) % N))) || s_nota !== exp_seg) begin
            n_fail++;
            $display("FAIL en_dark_next: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                     anodo, s_nota, exp_an, exp_seg);
        end
    endtask

    task automatic test_load_at_advance();
        logic [15:0] old_w;
        logic [15:0] new_w;
        int d;
        old_w = 16'h5678;
        new_w = 16'h9123;
        step(1'b1, 1'b1, old_w);
        for (int g = 0; g < 2 * DIV && (t % DIV) != 0; g++) step(1'b1, 1'b0, old_w);
        d = (t / DIV) % N;
        step(1'b1, 1'b1, new_w);
        n_tests++;
        if (anodo !== 4'(~(4'b0001 << d)) || s_nota !== seg_tab[old_w[4*d +: 4]]) begin
            n_fail++;
            $display("FAIL adv_old: anodo=%b s_nota=%b expected s_nota=%b",
                     anodo, s_nota, seg_tab[old_w[4*d +: 4]]);
        end
        step(1'b1, 1'b0, new_w);
        n_tests++;
        if (anodo !== 4'(~(4'b0001 << d)) || s_nota !== seg_tab[new_w[4*d +: 4]]) begin
            n_fail++;
            $display("FAIL adv_new: anodo=%b s_nota=%b expected s_nota=%b",
                     anodo, s_nota, seg_tab[new_w[4*d +: 4]]);
        end
    endtask

    task automatic test_blank_zeros();
        logic [6:0] want [N];
`ifdef DISPLAY7SEG_MUX_BLANK_ZEROS_EN
        want = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
`else
        want = '{7'b0000001, 7'b0100100, 7'b0000001, 7'b0000001};
`endif
        step(1'b1, 1'b1, 16'h0050);
        for (int k = 0; k < N * DIV + 1; k++) begin
            step(1'b1, 1'b0, 16'h0050);
            n_tests++;
            if (anodo !== exp_an || (lit_d >= 0 && s_nota !== want[lit_d])) begin
                n_fail++;
                $display("FAIL zeros cyc %0d: anodo=%b s_nota=%b expected anodo=%b",
                         k, anodo, s_nota, exp_an);
            end
        end
    endtask

    task automatic test_random();
        logic e;
        logic ld;
        logic [15:0] nv;
        nv = nota;
        for (int k = 0; k < 400; k++) begin
            e  = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 5) == 0);
            if (ld) nv = 16'($urandom);
            step(e, ld, nv);
            n_tests++;
            if (anodo !== exp_an || s_nota !== exp_seg) begin
                n_fail++;
                $display("FAIL random cyc %0d: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                         k, anodo, s_nota, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_reset_midscan();
        step(1'b1, 1'b1, 16'h4321);
        repeat (5) step(1'b1, 1'b0, 16'h4321);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (anodo !== 4'hF || s_nota !== 7'b1111111) begin
            n_fail++;
            $display("FAIL rst_async: anodo=%b s_nota=%b expected 1111 1111111", anodo, s_nota);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 16'h4321);
        n_tests++;
        if (anodo !== 4'hE || s_nota !== exp_seg) begin
            n_fail++;
            $display("FAIL rst_restart: anodo=%b s_nota=%b expected anodo=1110 s_nota=%b",
                     anodo, s_nota, exp_seg);
        end
        for (int k = 0; k < 2 * DIV; k++) begin
            step(1'b1, 1'b0, 16'h4321);
            n_tests++;
            if (anodo !== exp_an || s_nota !== exp_seg) begin
                n_fail++;
                $display("FAIL rst_rescan cyc %0d: anodo=%b s_nota=%b expected anodo=%b s_nota=%b",
                         k, anodo, s_nota, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        model_reset();
        test_reset();
        test_scan();
        test_digits(16'h1234, "digits_1234");
        test_digits(16'h12B4, "digits_invalid");
        test_en_drop();
        test_load_at_advance();
        test_blank_zeros();
        test_random();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
